// File: rtl/apb_completer.sv
// APB completer: each APB transfer becomes exactly one access on a single-port synchronous memory.
// Optional macro APB_SLVERR_EN enables the misaligned/out-of-range decode and the slverr response.
module apb_completer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_SIZE   = DATA_WIDTH / 8,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sel,
  input  logic                         enable,
  input  logic                         write,
  input  logic [STRB_SIZE-1:0]         strobe,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic                         ready,
  output logic                         slverr,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [STRB_SIZE-1:0]         mem_be,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int MAW = $clog2(MEM_DEPTH);
  localparam int BL  = $clog2(STRB_SIZE);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [MAW-1:0]        waddr_q, waddr_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [STRB_SIZE-1:0]  strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic           err_in;
  logic           setup;
  logic           active;
  logic           first;
  logic           rd_setup;
  logic           wr_cmt;
  logic [MAW-1:0] waddr_in;
  logic           unused_addr;

  assign waddr_in    = addr[BL +: MAW];
  assign unused_addr = ^addr;

`ifdef APB_SLVERR_EN
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_SIZE);
  assign err_in = (addr[1:0] != 2'b00) | ({1'b0, addr} >= LIMIT);
`else
  assign err_in = 1'b0;
`endif

  assign setup  = (state_q == IDLE) & sel & ~enable;
  assign active = (state_q == ACCESS) & sel & enable;
  // The counter is loaded with WAIT_STATES, so this value marks the first ACCESS cycle.
  assign first  = (cnt_q == 4'(WAIT_STATES));

  assign ready  = ~rst & active & (cnt_q == 4'd0);
  assign slverr = ready & err_q;

  // Reads fetch during SETUP so the word is on mem_rdata by the first ACCESS cycle.
  assign rd_setup = ~rst & setup & ~write & ~err_in;
  assign wr_cmt   = ready & write_q & ~err_q;

  assign mem_en    = rd_setup | wr_cmt;
  assign mem_wr    = wr_cmt;
  assign mem_addr  = rd_setup ? waddr_in : waddr_q;
  assign mem_be    = wr_cmt ? strobe_q : {STRB_SIZE{1'b1}};
  assign mem_wdata = wdata_q;
  assign rdata     = (ready & ~write_q & ~err_q) ? (first ? mem_rdata : hold_q) : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    write_d  = write_q;
    err_d    = err_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d  = ACCESS;
          cnt_d    = 4'(WAIT_STATES);
          waddr_d  = waddr_in;
          write_d  = write;
          err_d    = err_in;
          strobe_d = strobe;
          wdata_d  = wdata;
        end
      end
      ACCESS: begin
        if (active && first) hold_d = mem_rdata;
        if (!active || cnt_q == 4'd0) state_d = IDLE;
        else                          cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      waddr_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      strobe_q <= '0;
      wdata_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      write_q  <= write_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
    end
  end

endmodule
